p2s_ctrl_cond: RTL and testbench
================================

# p2s_ctrl_cond

Sequencing controller for the 4-lane parallel-to-serial converter in the byte-striping path. It generates the converter's load enable, valid-in and 3-bit bit-select so that each striped 32-bit word (four lanes × 8 bits) is serialized over exactly 8 clock cycles, back-to-back with no gap. It accepts words from the byte-striper through a valid/ready handshake, fills gaps with invalid (idle) bytes, and completes any byte in progress before stopping.

## Interface
Parameters:
- MSB_FIRST, 1, 1: bit-select counts 7→0; 0: counts 0→7.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- IN_CLK_p2s  input  1  bit clock; same clock as the converter.
- IN_RESET_p2s  input  1  synchronous, active-low reset.
- IN_TX_EN_ctrl  input  1  transmit enable; sampled every cycle.
- IN_VALID_BS  input  1  byte-striper has a word on the lane buses.
- OUT_READY_ctrl  output  1  word accepted this cycle when high together with IN_VALID_BS.
- OUT_ENB_p2s  output  1  one-cycle load strobe to the converter's lane registers.
- OUT_VALID_p2s  output  1  valid-in to the converter; high while the loaded byte is real data.
- OUT_CTR_p2s  output  3  bit-select to the converter's lane muxes.
- OUT_BUSY_ctrl  output  1  high while a byte is being shifted.
- OUT_WORDS_ctrl  output  CNT_W  count of accepted words.

## Operation
- FIRST = 7 and LAST = 0 when MSB_FIRST=1; FIRST = 0 and LAST = 7 otherwise.
- States: IDLE, LOAD, RUN.
- IDLE: OUT_CTR_p2s held at FIRST. OUT_ENB_p2s, OUT_READY_ctrl and OUT_BUSY_ctrl are 0. If IN_TX_EN_ctrl=1, go to LOAD.
- LOAD (one cycle): OUT_ENB_p2s=1 and OUT_READY_ctrl=1. Go to RUN with OUT_CTR_p2s=FIRST.
- RUN: OUT_BUSY_ctrl=1. OUT_CTR_p2s steps one position per cycle toward LAST.
  - Not at LAST: continue stepping.
  - At LAST with IN_TX_EN_ctrl=1: reload in the same cycle (OUT_ENB_p2s=1, OUT_READY_ctrl=1). OUT_CTR_p2s wraps to FIRST on the next cycle and the state stays RUN.
  - At LAST with IN_TX_EN_ctrl=0: no reload. Go to IDLE.
- OUT_READY_ctrl = OUT_ENB_p2s always. Both are combinational from state, counter and IN_TX_EN_ctrl.
- On every load edge, OUT_VALID_p2s is registered to IN_VALID_BS and held until the next load edge. If IN_VALID_BS=0 at load, the byte is shifted as idle (OUT_VALID_p2s=0) and no word is consumed.
- Entering IDLE clears OUT_VALID_p2s to 0.
- OUT_WORDS_ctrl increments by 1 on each edge where OUT_READY_ctrl & IN_VALID_BS. It is modulo 2^CNT_W and wraps from all-ones to 0 silently.
- Dropping IN_TX_EN_ctrl mid-byte never truncates the byte. The counter always completes FIRST..LAST.
- Toggling IN_TX_EN_ctrl during RUN at any count other than LAST has no effect.

## Timing
- All outputs are registered except OUT_ENB_p2s and OUT_READY_ctrl.
- Reset (IN_RESET_p2s=0 at an edge) gives: state IDLE, OUT_CTR_p2s=FIRST, OUT_VALID_p2s=0, OUT_BUSY_ctrl=0, OUT_WORDS_ctrl=0. OUT_ENB_p2s and OUT_READY_ctrl are 0 during reset.
- Reset overrides everything, including reset mid-byte. The partial byte is abandoned, with no further load and no count.
- Start latency: IN_TX_EN_ctrl rises at edge n → LOAD during cycle n+1 → first serial bit (OUT_CTR_p2s=FIRST with new data) during cycle n+2.
- Steady-state period is exactly 8 cycles per word. The load strobe falls in the LAST cycle and there are no bubble cycles between bytes.
- Upstream must hold the lane buses and IN_VALID_BS stable in any cycle where OUT_READY_ctrl=1. Data is captured on that cycle's rising edge.
- If IN_VALID_BS and OUT_READY_ctrl are simultaneous, the transfer happens. A valid word presented outside a ready cycle waits; it is neither lost nor counted.

## Test plan
- Reset then hold: IN_RESET_p2s=0 for 3 cycles with IN_TX_EN_ctrl=1 → OUT_CTR_p2s=7, OUT_ENB_p2s=0, OUT_WORDS_ctrl=0; first LOAD occurs 1 cycle after release.
- Continuous stream, MSB_FIRST=1, IN_VALID_BS=1 constant for 4 words → OUT_CTR_p2s sequence 7,6,…,0 repeated 4×. OUT_ENB_p2s is high on LOAD and then on every cycle with ctr=0. OUT_WORDS_ctrl=4 after 4 ready cycles.
- Gap fill: IN_VALID_BS=0 for one load → that byte has OUT_VALID_p2s=0 for 8 cycles and the count does not advance. The next valid word loads at the following ctr=0 cycle.
- Stop mid-byte: IN_TX_EN_ctrl falls while ctr=4 → counter continues 3,2,1,0 with no load at 0. The state goes to IDLE, ctr holds 7 and OUT_BUSY_ctrl=0 the following cycle.
- Reset mid-byte at ctr=3 → next cycle ctr=7, OUT_VALID_p2s=0, no ENB pulse. Count is cleared even if it was nonzero.
- Wrap/ordering: CNT_W=4, MSB_FIRST=0, 17 valid words → ctr counts 0→7 per byte and OUT_WORDS_ctrl reads 1 (15→0→1).

Source files
------------

// File: rtl/p2s_ctrl_cond_if.sv
// Handshake and converter-control bundle for the p2s sequencing controller.
// The master side is the controller; the slave side is the striper/converter pair.
interface p2s_ctrl_cond_if #(
  parameter int CNT_W = 16
);
  logic             IN_TX_EN_ctrl;
  logic             IN_VALID_BS;
  logic             OUT_READY_ctrl;
  logic             OUT_ENB_p2s;
  logic             OUT_VALID_p2s;
  logic [2:0]       OUT_CTR_p2s;
  logic             OUT_BUSY_ctrl;
  logic [CNT_W-1:0] OUT_WORDS_ctrl;

  modport master (
    input  IN_TX_EN_ctrl, IN_VALID_BS,
    output OUT_READY_ctrl, OUT_ENB_p2s, OUT_VALID_p2s, OUT_CTR_p2s,
           OUT_BUSY_ctrl, OUT_WORDS_ctrl
  );

  modport slave (
    output IN_TX_EN_ctrl, IN_VALID_BS,
    input  OUT_READY_ctrl, OUT_ENB_p2s, OUT_VALID_p2s, OUT_CTR_p2s,
           OUT_BUSY_ctrl, OUT_WORDS_ctrl
  );
endinterface

// File: rtl/p2s_ctrl_cond.sv
// Sequencer for the 4-lane parallel-to-serial converter: one 32-bit word every
// 8 bit clocks, back-to-back, idle-filled when the striper has nothing ready.
module p2s_ctrl_cond #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              IN_CLK_p2s,
  input  logic              IN_RESET_p2s,
  p2s_ctrl_cond_if.master   bus
);

  localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;
  // Adding 7 modulo 8 is a decrement, so one adder covers both orders.
  localparam logic [2:0] STEP  = MSB_FIRST ? 3'd7 : 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ctr_q,   ctr_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             load;
  logic             accept;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    ctr_d   = ctr_q;
    valid_d = valid_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        ctr_d = FIRST;
        if (bus.IN_TX_EN_ctrl) state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        ctr_d   = FIRST;
        state_d = RUN;
      end
      RUN: begin
        if (ctr_q != LAST) begin
          ctr_d = ctr_q + STEP;
        end else if (bus.IN_TX_EN_ctrl) begin
          load  = 1'b1;
          ctr_d = FIRST;
        end else begin
          state_d = IDLE;
          ctr_d   = FIRST;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ctr_d   = FIRST;
        valid_d = 1'b0;
      end
    endcase

    // The strobe is combinational, so it must be forced low while reset is held.
    load = load & IN_RESET_p2s;
    if (load) valid_d = bus.IN_VALID_BS;

    accept  = load & bus.IN_VALID_BS;
    busy_d  = (state_d == RUN);
    words_d = words_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge IN_CLK_p2s) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!IN_RESET_p2s) begin
      state_q <= IDLE;
      ctr_q   <= FIRST;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      words_q <= words_d;
    end
  end

  assign bus.OUT_ENB_p2s    = load;
  assign bus.OUT_READY_ctrl = load;
  assign bus.OUT_VALID_p2s  = valid_q;
  assign bus.OUT_CTR_p2s    = ctr_q;
  assign bus.OUT_BUSY_ctrl  = busy_q;
  assign bus.OUT_WORDS_ctrl = words_q;

endmodule

// File: tb/tb_p2s_ctrl_cond.sv
// Directed bench for p2s_ctrl_cond: an MSB-first 16-bit-count instance and an
// LSB-first 4-bit-count instance exercised from hand-computed vectors.
module tb_p2s_ctrl_cond;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  p2s_ctrl_cond_if #(.CNT_W(16)) bus0 ();
  p2s_ctrl_cond_if #(.CNT_W(4))  bus1 ();

  p2s_ctrl_cond #(.MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
    .IN_CLK_p2s   (clk),
    .IN_RESET_p2s (rst_n),
    .bus          (bus0)
  );

  p2s_ctrl_cond #(.MSB_FIRST(1'b0), .CNT_W(4)) dut1 (
    .IN_CLK_p2s   (clk),
    .IN_RESET_p2s (rst_n),
    .bus          (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.IN_TX_EN_ctrl = 1'b1;
    bus0.IN_VALID_BS   = 1'b1;
    bus1.IN_TX_EN_ctrl = 1'b0;
    bus1.IN_VALID_BS   = 1'b0;

    // Reset held for 3 cycles with transmit enabled: nothing may start.
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_ctr",   bus0.OUT_CTR_p2s,    7);
      check("rst_enb",   bus0.OUT_ENB_p2s,    0);
      check("rst_ready", bus0.OUT_READY_ctrl, 0);
      check("rst_words", bus0.OUT_WORDS_ctrl, 0);
      check("rst_valid", bus0.OUT_VALID_p2s,  0);
      check("rst_busy",  bus0.OUT_BUSY_ctrl,  0);
    end

    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_idle_enb", bus0.OUT_ENB_p2s, 0);
    @(negedge clk); #1;
    check("load_enb",   bus0.OUT_ENB_p2s,    1);
    check("load_ready", bus0.OUT_READY_ctrl, 1);
    check("load_ctr",   bus0.OUT_CTR_p2s,    7);
    check("load_busy",  bus0.OUT_BUSY_ctrl,  0);

    // Four back-to-back valid words; enable drops at ctr=4 of the fourth.
    for (int w = 1; w <= 4; w++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (w == 4 && k == 3) bus0.IN_TX_EN_ctrl = 1'b0;
        #1;
        check("str_ctr",   bus0.OUT_CTR_p2s,    7 - k);
        check("str_busy",  bus0.OUT_BUSY_ctrl,  1);
        check("str_valid", bus0.OUT_VALID_p2s,  1);
        check("str_words", bus0.OUT_WORDS_ctrl, w);
        check("str_enb",   bus0.OUT_ENB_p2s,    (k == 7 && w < 4) ? 1 : 0);
        check("str_ready", bus0.OUT_READY_ctrl, (k == 7 && w < 4) ? 1 : 0);
      end
    end
    @(negedge clk); #1;
    check("stop_ctr",   bus0.OUT_CTR_p2s,    7);
    check("stop_busy",  bus0.OUT_BUSY_ctrl,  0);
    check("stop_valid", bus0.OUT_VALID_p2s,  0);
    check("stop_enb",   bus0.OUT_ENB_p2s,    0);
    check("stop_words", bus0.OUT_WORDS_ctrl, 4);

    // Gap fill: first load sees no valid word, the next one does.
    @(negedge clk); bus0.IN_TX_EN_ctrl = 1'b1; bus0.IN_VALID_BS = 1'b1; #1;
    check("gap_idle_enb", bus0.OUT_ENB_p2s, 0);
    @(negedge clk); bus0.IN_VALID_BS = 1'b0; #1;
    check("gap_load_enb", bus0.OUT_ENB_p2s, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) bus0.IN_VALID_BS = 1'b1;
      #1;
      check("gap_ctr",   bus0.OUT_CTR_p2s,    7 - k);
      check("gap_valid", bus0.OUT_VALID_p2s,  0);
      check("gap_words", bus0.OUT_WORDS_ctrl, 4);
      check("gap_enb",   bus0.OUT_ENB_p2s,    (k == 7) ? 1 : 0);
    end

    // Reset lands mid-byte at ctr=3.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) rst_n = 1'b0;
      #1;
      check("mid_ctr",   bus0.OUT_CTR_p2s,    7 - k);
      check("mid_valid", bus0.OUT_VALID_p2s,  1);
      check("mid_words", bus0.OUT_WORDS_ctrl, 5);
    end
    check("mid_rst_enb", bus0.OUT_ENB_p2s, 0);
    @(negedge clk); #1;
    check("mrst_ctr",   bus0.OUT_CTR_p2s,    7);
    check("mrst_valid", bus0.OUT_VALID_p2s,  0);
    check("mrst_enb",   bus0.OUT_ENB_p2s,    0);
    check("mrst_busy",  bus0.OUT_BUSY_ctrl,  0);
    check("mrst_words", bus0.OUT_WORDS_ctrl, 0);
    @(negedge clk); rst_n = 1'b1; bus0.IN_TX_EN_ctrl = 1'b0; #1;

    // LSB-first, 4-bit counter: 17 words wrap the count 15 -> 0 -> 1.
    @(negedge clk); bus1.IN_TX_EN_ctrl = 1'b1; bus1.IN_VALID_BS = 1'b1; #1;
    check("lsb_idle_ctr", bus1.OUT_CTR_p2s, 0);
    @(negedge clk); #1;
    check("lsb_load_enb",   bus1.OUT_ENB_p2s,    1);
    check("lsb_load_words", bus1.OUT_WORDS_ctrl, 0);
    for (int w = 1; w <= 17; w++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (w == 17 && k == 3) bus1.IN_TX_EN_ctrl = 1'b0;
        #1;
        check("lsb_ctr",   bus1.OUT_CTR_p2s,    k);
        check("lsb_valid", bus1.OUT_VALID_p2s,  1);
        check("lsb_words", bus1.OUT_WORDS_ctrl, w % 16);
        check("lsb_enb",   bus1.OUT_ENB_p2s,    (k == 7 && w < 17) ? 1 : 0);
      end
    end
    @(negedge clk); #1;
    check("lsb_end_ctr",   bus1.OUT_CTR_p2s,    0);
    check("lsb_end_busy",  bus1.OUT_BUSY_ctrl,  0);
    check("lsb_end_words", bus1.OUT_WORDS_ctrl, 1);
    check("msb_quiet_words", bus0.OUT_WORDS_ctrl, 0);
    check("msb_quiet_busy",  bus0.OUT_BUSY_ctrl,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
